// File: rtl/hazard_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_stage
// Description : ID/EX control-stage register with load-use hazard detection,
//               multi-cycle bubble insertion, branch flush, external freeze
//               and a saturating bubble counter for performance debug.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl_stage #(
    parameter int CTRL_W       = 20,
    parameter int MEMREAD_LSB  = 5,
    parameter int REG_AW       = 5,
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [CTRL_W-1:0] CtrlIn,
    input  logic [REG_AW-1:0] IDRs,
    input  logic [REG_AW-1:0] IDRt,
    input  logic              IDUsesRt,
    input  logic [REG_AW-1:0] IDDst,
    input  logic              Flush,
    input  logic              ExtStall,
    output logic [CTRL_W-1:0] CtrlOut,
    output logic [REG_AW-1:0] EXDst,
    output logic              PCWrite,
    output logic              IFIDWrite,
    output logic              Bubble,
    output logic [CNT_W-1:0]  BubbleCount
);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    // Bubbles still owed after the hazard cycle itself.
    localparam logic [2:0]       c_STALL_RELOAD = 3'(STALL_CYCLES - 1);
    localparam bit               c_MULTI_CYCLE  = (STALL_CYCLES > 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX      = '1;

    state_t              r_state;
    state_t              w_stateNext;
    logic [2:0]          r_remaining;
    logic [2:0]          w_remainingNext;
    logic [CTRL_W-1:0]   r_ctrl;
    logic [CTRL_W-1:0]   w_ctrlNext;
    logic [REG_AW-1:0]   r_dst;
    logic [REG_AW-1:0]   w_dstNext;
    logic [CNT_W-1:0]    r_count;
    logic                w_loadInEx;
    logic                w_srcMatch;
    logic                w_hazard;

    assign CtrlOut     = r_ctrl;
    assign EXDst       = r_dst;
    assign BubbleCount = r_count;

    // A load in EX whose destination feeds the ID instruction; $0 never hazards.
    assign w_loadInEx = |r_ctrl[MEMREAD_LSB+1:MEMREAD_LSB];
    assign w_srcMatch = (r_dst == IDRs) || (IDUsesRt && (r_dst == IDRt));
    assign w_hazard   = (r_state == ST_RUN) && w_loadInEx && (r_dst != '0) && w_srcMatch;

    // Next-state and fetch-control decode, priority ExtStall > Flush > stall > run.
    always_comb begin
        w_stateNext     = r_state;
        w_remainingNext = r_remaining;
        w_ctrlNext      = r_ctrl;
        w_dstNext       = r_dst;
        PCWrite         = 1'b1;
        IFIDWrite       = 1'b1;
        Bubble          = 1'b0;

        if (Reset) begin
            // Fetch stays enabled while the stage is held in reset.
        end else if (ExtStall) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
        end else if (Flush) begin
            w_stateNext     = ST_RUN;
            w_remainingNext = 3'd0;
            w_ctrlNext      = '0;
            w_dstNext       = '0;
        end else if (r_state == ST_STALL) begin
            PCWrite         = 1'b0;
            IFIDWrite       = 1'b0;
            Bubble          = 1'b1;
            w_ctrlNext      = '0;
            w_dstNext       = '0;
            w_remainingNext = r_remaining - 3'd1;
            if (r_remaining == 3'd1) begin
                w_stateNext = ST_RUN;
            end
        end else if (w_hazard) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            Bubble     = 1'b1;
            w_ctrlNext = '0;
            w_dstNext  = '0;
            if (c_MULTI_CYCLE) begin
                w_stateNext     = ST_STALL;
                w_remainingNext = c_STALL_RELOAD;
            end
        end else begin
            w_ctrlNext = CtrlIn;
            w_dstNext  = IDDst;
        end
    end

    // Pipeline register and stall state.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= ST_RUN;
            r_remaining <= 3'd0;
            r_ctrl      <= '0;
            r_dst       <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_remaining <= w_remainingNext;
            r_ctrl      <= w_ctrlNext;
            r_dst       <= w_dstNext;
        end
    end

    // Saturating count of inserted hazard bubbles (flushes are not counted).
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_count <= '0;
        end else if (Bubble && !ExtStall && (r_count != c_CNT_MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl_stage
// Description : Self-checking bench for hazard_ctrl_stage. Three instances
//               (1-cycle stall, 3-cycle stall, 4-bit counter) share stimulus
//               and are compared against a bubble-budget reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl_stage;

    localparam int CW = 20;
    localparam int AW = 5;
    localparam logic [CW-1:0] c_LW  = 20'h80020;  // RegWrite + MemRead=01
    localparam logic [CW-1:0] c_ADD = 20'h80300;  // RegWrite + ALU op, no MemRead

    logic          Clk = 1'b0;
    logic          Reset;
    logic [CW-1:0] CtrlIn;
    logic [AW-1:0] IDRs, IDRt, IDDst;
    logic          IDUsesRt, Flush, ExtStall;

    logic [CW-1:0] ctrlA, ctrlB, ctrlC;
    logic [AW-1:0] dstA, dstB, dstC;
    logic          pcwA, pcwB, pcwC, ifidA, ifidB, ifidC, bubA, bubB, bubC;
    logic [15:0]   cntA, cntB;
    logic [3:0]    cntC;

    int nChecks = 0;
    int nFails  = 0;

    // Reference model: per instance, EX contents, bubbles still owed, counter.
    logic [CW-1:0] mCtrl [3];
    logic [AW-1:0] mDst  [3];
    int            mLeft [3];
    int            mCount[3];
    int            cStall[3] = '{1, 3, 1};
    int            cMax  [3] = '{65535, 65535, 15};

    always #5 Clk = ~Clk;

    hazard_ctrl_stage #(.CTRL_W(CW), .MEMREAD_LSB(5), .REG_AW(AW), .STALL_CYCLES(1), .CNT_W(16)) u1 (
        .Clk(Clk), .Reset(Reset), .CtrlIn(CtrlIn), .IDRs(IDRs), .IDRt(IDRt), .IDUsesRt(IDUsesRt),
        .IDDst(IDDst), .Flush(Flush), .ExtStall(ExtStall), .CtrlOut(ctrlA), .EXDst(dstA),
        .PCWrite(pcwA), .IFIDWrite(ifidA), .Bubble(bubA), .BubbleCount(cntA));

    hazard_ctrl_stage #(.CTRL_W(CW), .MEMREAD_LSB(5), .REG_AW(AW), .STALL_CYCLES(3), .CNT_W(16)) u3 (
        .Clk(Clk), .Reset(Reset), .CtrlIn(CtrlIn), .IDRs(IDRs), .IDRt(IDRt), .IDUsesRt(IDUsesRt),
        .IDDst(IDDst), .Flush(Flush), .ExtStall(ExtStall), .CtrlOut(ctrlB), .EXDst(dstB),
        .PCWrite(pcwB), .IFIDWrite(ifidB), .Bubble(bubB), .BubbleCount(cntB));

    hazard_ctrl_stage #(.CTRL_W(CW), .MEMREAD_LSB(5), .REG_AW(AW), .STALL_CYCLES(1), .CNT_W(4)) uSat (
        .Clk(Clk), .Reset(Reset), .CtrlIn(CtrlIn), .IDRs(IDRs), .IDRt(IDRt), .IDUsesRt(IDUsesRt),
        .IDDst(IDDst), .Flush(Flush), .ExtStall(ExtStall), .CtrlOut(ctrlC), .EXDst(dstC),
        .PCWrite(pcwC), .IFIDWrite(ifidC), .Bubble(bubC), .BubbleCount(cntC));

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // The instance must insert a bubble now: owed bubbles, or a fresh load-use.
    function automatic bit stallingNow(input int i);
        bit useHit;
        useHit = (mDst[i] == IDRs) || (IDUsesRt && (mDst[i] == IDRt));
        return (mLeft[i] > 0) || ((|mCtrl[i][6:5]) && (mDst[i] != '0) && useHit);
    endfunction

    task automatic checkInst(input int i, input logic [CW-1:0] ctrl, input logic [AW-1:0] dst,
                             input logic pcw, input logic ifid, input logic bub, input logic [15:0] cnt);
        bit ePcw, eBub, s;
        s = stallingNow(i);
        if (Reset)         begin ePcw = 1; eBub = 0; end
        else if (ExtStall) begin ePcw = 0; eBub = 0; end
        else if (Flush)    begin ePcw = 1; eBub = 0; end
        else               begin ePcw = !s; eBub = s; end
        checkEq($sformatf("u%0d_ctrl", i), 32'(ctrl), 32'(mCtrl[i]));
        checkEq($sformatf("u%0d_dst", i),  32'(dst),  32'(mDst[i]));
        checkEq($sformatf("u%0d_pcw", i),  32'(pcw),  32'(ePcw));
        checkEq($sformatf("u%0d_ifid", i), 32'(ifid), 32'(ePcw));
        checkEq($sformatf("u%0d_bub", i),  32'(bub),  32'(eBub));
        checkEq($sformatf("u%0d_cnt", i),  32'(cnt),  32'(mCount[i]));
    endtask

    task automatic checkAll();
        checkInst(0, ctrlA, dstA, pcwA, ifidA, bubA, cntA);
        checkInst(1, ctrlB, dstB, pcwB, ifidB, bubB, cntB);
        checkInst(2, ctrlC, dstC, pcwC, ifidC, bubC, {12'd0, cntC});
    endtask

    task automatic modelReset();
        for (int i = 0; i < 3; i++) begin
            mCtrl[i] = '0; mDst[i] = '0; mLeft[i] = 0; mCount[i] = 0;
        end
    endtask

    // Advance the model across one rising edge using the inputs held over it.
    task automatic modelStep();
        bit s;
        if (Reset) begin
            modelReset();
        end else if (!ExtStall) begin
            for (int i = 0; i < 3; i++) begin
                s = stallingNow(i);
                if (Flush) begin
                    mCtrl[i] = '0; mDst[i] = '0; mLeft[i] = 0;
                end else if (s) begin
                    mLeft[i]  = (mLeft[i] > 0) ? mLeft[i] - 1 : cStall[i] - 1;
                    mCtrl[i]  = '0;
                    mDst[i]   = '0;
                    if (mCount[i] < cMax[i]) mCount[i]++;
                end else begin
                    mCtrl[i] = CtrlIn;
                    mDst[i]  = IDDst;
                end
            end
        end
    endtask

    task automatic setIn(input logic [CW-1:0] c, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input logic uses, input logic [AW-1:0] d, input logic fl, input logic ex);
        CtrlIn = c; IDRs = rs; IDRt = rt; IDUsesRt = uses; IDDst = d; Flush = fl; ExtStall = ex;
    endtask

    // One clock: drive, check mid-cycle, cross the edge, update model.
    task automatic cyc(input logic [CW-1:0] c, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic uses, input logic [AW-1:0] d, input logic fl, input logic ex);
        setIn(c, rs, rt, uses, d, fl, ex);
        #2;
        checkAll();
        @(posedge Clk);
        modelStep();
        #1;
    endtask

    task automatic doReset();
        Reset = 1'b1;
        #1;
        modelReset();
        checkAll();
        @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        setIn('0, '0, '0, 1'b0, '0, 1'b0, 1'b0);
        #1;
        modelReset();
        checkAll();
        @(posedge Clk);
        #1;
        Reset = 1'b0;

        // Load-use: lw $8 then add using $8.
        cyc(c_LW, 5'd0, 5'd0, 1'b0, 5'd8, 1'b0, 1'b0);
        cyc(c_ADD, 5'd8, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0);
        checkEq("lu1_bubble_ctrl", 32'(ctrlA), 32'd0);
        cyc(c_ADD, 5'd8, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0);
        checkEq("lu1_add_ctrl", 32'(ctrlA), 32'(c_ADD));
        checkEq("lu1_count", 32'(cntA), 32'd1);
        cyc(c_ADD, 5'd8, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0);
        cyc(c_ADD, 5'd8, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0);
        checkEq("lu3_add_ctrl", 32'(ctrlB), 32'(c_ADD));
        checkEq("lu3_count", 32'(cntB), 32'd3);

        // No false hazards.
        doReset();
        cyc(c_LW, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        cyc(c_ADD, 5'd0, 5'd0, 1'b1, 5'd9, 1'b0, 1'b0);
        checkEq("nofalse_r0", 32'(ctrlB), 32'(c_ADD));
        cyc(c_LW, 5'd0, 5'd0, 1'b0, 5'd8, 1'b0, 1'b0);
        cyc(c_ADD, 5'd1, 5'd8, 1'b0, 5'd9, 1'b0, 1'b0);
        checkEq("nofalse_rt", 32'(ctrlB), 32'(c_ADD));
        cyc(c_ADD, 5'd0, 5'd0, 1'b0, 5'd8, 1'b0, 1'b0);
        cyc(c_ADD, 5'd8, 5'd8, 1'b1, 5'd9, 1'b0, 1'b0);
        checkEq("nofalse_nonload", 32'(ctrlB), 32'(c_ADD));

        // Flush on the second bubble of a 3-cycle stall.
        doReset();
        cyc(c_LW, 5'd0, 5'd0, 1'b0, 5'd8, 1'b0, 1'b0);
        cyc(c_ADD, 5'd8, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0);
        cyc(c_ADD, 5'd8, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
        checkEq("flush_ctrl", 32'(ctrlB), 32'd0);
        checkEq("flush_count", 32'(cntB), 32'd1);
        cyc(c_ADD, 5'd8, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0);
        checkEq("flush_resume", 32'(ctrlB), 32'(c_ADD));

        // ExtStall for 4 cycles mid-stall, then resume.
        doReset();
        cyc(c_LW, 5'd0, 5'd0, 1'b0, 5'd8, 1'b0, 1'b0);
        cyc(c_ADD, 5'd8, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0);
        repeat (4) cyc(c_ADD, 5'd8, 5'd0, 1'b0, 5'd9, 1'b0, 1'b1);
        checkEq("ext_count_frozen", 32'(cntB), 32'd1);
        checkEq("ext_ctrl_frozen", 32'(ctrlB), 32'd0);
        repeat (3) cyc(c_ADD, 5'd8, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0);
        checkEq("ext_resume_ctrl", 32'(ctrlB), 32'(c_ADD));
        checkEq("ext_resume_count", 32'(cntB), 32'd3);

        // Async reset one bubble into a 3-cycle stall.
        doReset();
        cyc(c_LW, 5'd0, 5'd0, 1'b0, 5'd8, 1'b0, 1'b0);
        cyc(c_ADD, 5'd8, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0);
        setIn(c_ADD, 5'd8, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0);
        #2;
        checkAll();
        Reset = 1'b1;
        #1;
        checkEq("rstmid_ctrl", 32'(ctrlB), 32'd0);
        checkEq("rstmid_count", 32'(cntB), 32'd0);
        checkEq("rstmid_pcw", 32'(pcwB), 32'd1);
        checkEq("rstmid_bub", 32'(bubB), 32'd0);
        modelReset();
        checkAll();
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        cyc(c_ADD, 5'd8, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0);
        checkEq("rstmid_run", 32'(ctrlB), 32'(c_ADD));

        // Saturation: 20 hazards into a 4-bit counter.
        doReset();
        repeat (20) begin
            cyc(c_LW, 5'd0, 5'd0, 1'b0, 5'd8, 1'b0, 1'b0);
            cyc(c_ADD, 5'd8, 5'd0, 1'b0, 5'd9, 1'b0, 1'b0);
        end
        checkEq("sat_count", 32'(cntC), 32'd15);

        // Randomized traffic.
        doReset();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) doReset();
            cyc(CW'($urandom) | (($urandom_range(0, 1) == 1) ? 20'h00020 : 20'h0),
                AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                AW'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl_stage.md
Name: hazard_ctrl_stage

Overview:
- Parametrised ID/EX control-stage register with built-in load-use hazard detection, multi-cycle bubble insertion, branch flush and external freeze.
- Replaces the combinational bubble mux between the Controller and the ID/EX register: it registers the decoded control word, or zeros it on a bubble or flush.
- It drives PCWrite/IFIDWrite back to the fetch stage.
- It keeps a saturating count of inserted bubbles for performance debug.

Parameters:
- CTRL_W, 20, width of packed control word (RegWrite, ALUSrc, RegDst, MemWrite[1:0], MemRead[1:0], MemToReg, Jump, Jr, Jal, ALUControl[4:0], ShiftControl, PCSrc, spare).
- MEMREAD_LSB, 5, bit index of MemRead[1:0] within the control word; "load in EX" = |CtrlOut[MEMREAD_LSB+1:MEMREAD_LSB].
- REG_AW, 5, register-address width.
- STALL_CYCLES, 1, bubbles inserted per load-use hazard; legal range 1..7.
- CNT_W, 16, width of bubble counter.

Ports:
- Clk  input  1  clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- CtrlIn  input  CTRL_W  decoded control word from Controller (ID).
- IDRs  input  REG_AW  rs field of instruction in ID.
- IDRt  input  REG_AW  rt field of instruction in ID.
- IDUsesRt  input  1  ID instruction reads rt as a source.
- IDDst  input  REG_AW  destination register selected in ID.
- Flush  input  1  taken branch/jump; squash instruction entering EX.
- ExtStall  input  1  global freeze (memory busy); hold all state.
- CtrlOut  output  CTRL_W  registered control word to EX.
- EXDst  output  REG_AW  registered destination register of EX instruction.
- PCWrite  output  1  PC update enable (combinational).
- IFIDWrite  output  1  IF/ID register enable (combinational).
- Bubble  output  1  a hazard bubble is being inserted this cycle (combinational).
- BubbleCount  output  CNT_W  saturating count of hazard bubbles.

Behaviour:
- Reset (async, any time, including mid-stall): CtrlOut=0, EXDst=0, state=RUN, remaining=0, BubbleCount=0. PCWrite=IFIDWrite=1 and Bubble=0 while Reset is asserted.
- Hazard = state RUN and load in EX and EXDst!=0 and (EXDst==IDRs, or IDUsesRt and EXDst==IDRt).
- States:
  - RUN: normal operation.
  - STALL: holds a 3-bit remaining count.
- Priority per edge: Reset > ExtStall > Flush > STALL/Hazard > normal.
- ExtStall=1:
  - CtrlOut, EXDst, state, remaining and BubbleCount all hold.
  - PCWrite=IFIDWrite=0, Bubble=0.
- Flush=1 (no ExtStall):
  - CtrlOut<=0, EXDst<=0, state<=RUN, remaining<=0.
  - PCWrite=IFIDWrite=1, Bubble=0.
  - A pending stall is cancelled.
  - Flush is not counted in BubbleCount.
- RUN with Hazard:
  - PCWrite=IFIDWrite=0, Bubble=1.
  - CtrlOut<=0, EXDst<=0.
  - If STALL_CYCLES>1: state<=STALL, remaining<=STALL_CYCLES-1. Otherwise stay in RUN.
- STALL:
  - PCWrite=IFIDWrite=0, Bubble=1, CtrlOut<=0, EXDst<=0, remaining<=remaining-1.
  - When remaining==1, state<=RUN. Hazard is not evaluated in STALL.
- RUN without Hazard: CtrlOut<=CtrlIn, EXDst<=IDDst, PCWrite=IFIDWrite=1, Bubble=0.
- Timing: CtrlIn reaches CtrlOut with 1-cycle latency.
- Bubble total: exactly STALL_CYCLES bubbles per hazard, absent Flush/ExtStall. After the last bubble, the held ID instruction proceeds in the next RUN cycle.
- BubbleCount increments on every edge where Bubble=1 and ExtStall=0. It saturates at all-ones, with no wrap.
- Register $0: EXDst==0 never creates a hazard.

Test Plan:
- Reset mid-stall: STALL_CYCLES=3, hazard, assert Reset after 1 bubble -> CtrlOut=0, state RUN, BubbleCount=0, PCWrite=1 immediately.
- Load-use, STALL_CYCLES=1:
  - Stimulus: lw to $8 (MemRead=01, IDDst=8), then add with IDRs=8.
  - Response: one cycle PCWrite=IFIDWrite=0, Bubble=1, CtrlOut=0 next edge.
  - Following edge: CtrlOut=add word. BubbleCount=1.
- Multi-cycle stall: STALL_CYCLES=3, same hazard -> exactly 3 consecutive Bubble=1 cycles, then add enters EX. BubbleCount=3.
- No false hazards:
  - lw to $0 followed by a use of $0 -> no stall.
  - lw $8 followed by an instruction with IDRt=8 and IDUsesRt=0 -> no stall.
  - Non-load in EX writing $8 followed by a use of $8 -> no stall.
- Flush during stall: STALL_CYCLES=3, Flush on 2nd bubble cycle -> CtrlOut=0, state RUN, PCWrite=1 next cycle. BubbleCount=1.
- ExtStall and saturation:
  - ExtStall for 4 cycles mid-stall -> CtrlOut/remaining/BubbleCount frozen, PCWrite=0, Bubble=0. The stall resumes after release.
  - CNT_W=4 with 20 hazards -> BubbleCount=15.
